// File: rtl/bus_arbiter_2.sv
// bus_arbiter_2: two-host round-robin arbiter in front of a single hub host port.
// A grant is held for a whole transaction. The owner's request is forwarded to the
// hub, and only the owner sees the read data and ready coming back. A watchdog ends
// transactions that the hub never acknowledges, such as accesses to unmapped addresses.
module bus_arbiter_2 #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] h0_address,
  input  logic [31:0] h0_data_write,
  input  logic [3:0]  h0_write_mask,
  input  logic        h0_ren,
  input  logic        h0_wen,
  output logic [31:0] h0_data_read,
  output logic        h0_ready,
  input  logic [31:0] h1_address,
  input  logic [31:0] h1_data_write,
  input  logic [3:0]  h1_write_mask,
  input  logic        h1_ren,
  input  logic        h1_wen,
  output logic [31:0] h1_data_read,
  output logic        h1_ready,
  output logic [31:0] dev_address,
  output logic [31:0] dev_data_write,
  output logic [3:0]  dev_write_mask,
  output logic        dev_ren,
  output logic        dev_wen,
  input  logic [31:0] dev_data_read,
  input  logic        dev_ready,
  output logic [1:0]  grant,
  output logic        bus_error
);

  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  // A zero timeout still needs a 1-bit counter so that the declarations stay legal.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            h0_req, h1_req;
  logic            own_sel;
  logic            own_req;
  logic            own_ren, own_wen;
  logic [DATA_W-1:0] own_addr, own_wdata;
  logic [MASK_W-1:0] own_mask;
  logic            own_ready;
  logic [DATA_W-1:0] own_rdata;
  logic            fwd_en;
  logic            fire;

  assign h0_req = h0_ren | h0_wen;
  assign h1_req = h1_ren | h1_wen;

  // Select the owning host's request fields; own_sel is 1 while host 1 holds the bus.
  always_comb begin
    own_sel   = (state_q == OWN1);
    own_req   = own_sel ? h1_req        : h0_req;
    own_ren   = own_sel ? h1_ren        : h0_ren;
    own_wen   = own_sel ? h1_wen        : h0_wen;
    own_addr  = own_sel ? h1_address    : h0_address;
    own_wdata = own_sel ? h1_data_write : h0_data_write;
    own_mask  = own_sel ? h1_write_mask : h0_write_mask;
  end

  // The watchdog fires only when the device stays silent; a late dev_ready still wins.
  always_comb begin
    fire = 1'b0;
    if (state_q != IDLE) begin
      fire = TMO_EN && (cnt_q == TMO) && !dev_ready;
    end
  end

  // Next-state logic, arbitration and the completion, timeout and abort handling.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    fwd_en    = 1'b0;
    own_ready = 1'b0;
    own_rdata = '0;
    bus_error = 1'b0;
    grant     = 2'b00;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // On a tie, the host that was not granted last time wins.
        if (h0_req && (!h1_req || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end else if (h1_req) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end
      end
      OWN0, OWN1: begin
        grant = own_sel ? 2'b10 : 2'b01;
        if (!own_req) begin
          // The host withdrew its request: drop the request to the hub and release the bus.
          own_rdata = dev_data_read;
          state_d   = IDLE;
        end else if (dev_ready) begin
          fwd_en    = 1'b1;
          own_ready = 1'b1;
          own_rdata = dev_data_read;
          state_d   = IDLE;
        end else if (fire) begin
          own_ready = 1'b1;
          bus_error = 1'b1;
          state_d   = IDLE;
        end else begin
          fwd_en    = 1'b1;
          own_rdata = dev_data_read;
          cnt_d     = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Drive the hub port. While idle every field is zero; strobes are gated on abort and timeout.
  always_comb begin
    dev_address    = '0;
    dev_data_write = '0;
    dev_write_mask = '0;
    dev_ren        = 1'b0;
    dev_wen        = 1'b0;
    if (state_q != IDLE) begin
      dev_address    = own_addr;
      dev_data_write = own_wdata;
      dev_write_mask = own_mask;
      dev_ren        = own_ren & fwd_en;
      dev_wen        = own_wen & fwd_en;
    end
  end

  // Route ready and read data back to the owning host only.
  always_comb begin
    h0_ready     = 1'b0;
    h1_ready     = 1'b0;
    h0_data_read = '0;
    h1_data_read = '0;
    if (state_q == OWN0) begin
      h0_ready     = own_ready;
      h0_data_read = own_rdata;
    end else if (state_q == OWN1) begin
      h1_ready     = own_ready;
      h1_data_read = own_rdata;
    end
  end

  // State, round-robin pointer and watchdog counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2.sv
// Directed testbench for bus_arbiter_2. The main instance uses TIMEOUT_CYCLES=4, and a
// second instance with the watchdog disabled shares the same stimulus.
module tb_bus_arbiter_2;

  logic        clk;
  logic        rst;
  logic [31:0] h0_address, h0_data_write, h1_address, h1_data_write;
  logic [3:0]  h0_write_mask, h1_write_mask;
  logic        h0_ren, h0_wen, h1_ren, h1_wen;
  logic [31:0] dev_data_read;
  logic        dev_ready;

  logic [31:0] h0_data_read, h1_data_read, dev_address, dev_data_write;
  logic        h0_ready, h1_ready, dev_ren, dev_wen, bus_error;
  logic [3:0]  dev_write_mask;
  logic [1:0]  grant;

  logic [31:0] h0_data_read_z, h1_data_read_z, dev_address_z, dev_data_write_z;
  logic        h0_ready_z, h1_ready_z, dev_ren_z, dev_wen_z, bus_error_z;
  logic [3:0]  dev_write_mask_z;
  logic [1:0]  grant_z;

  int vectors;
  int miscompares;

  bus_arbiter_2 #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .h0_address(h0_address), .h0_data_write(h0_data_write), .h0_write_mask(h0_write_mask),
    .h0_ren(h0_ren), .h0_wen(h0_wen), .h0_data_read(h0_data_read), .h0_ready(h0_ready),
    .h1_address(h1_address), .h1_data_write(h1_data_write), .h1_write_mask(h1_write_mask),
    .h1_ren(h1_ren), .h1_wen(h1_wen), .h1_data_read(h1_data_read), .h1_ready(h1_ready),
    .dev_address(dev_address), .dev_data_write(dev_data_write), .dev_write_mask(dev_write_mask),
    .dev_ren(dev_ren), .dev_wen(dev_wen), .dev_data_read(dev_data_read), .dev_ready(dev_ready),
    .grant(grant), .bus_error(bus_error)
  );

  bus_arbiter_2 #(.TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .h0_address(h0_address), .h0_data_write(h0_data_write), .h0_write_mask(h0_write_mask),
    .h0_ren(h0_ren), .h0_wen(h0_wen), .h0_data_read(h0_data_read_z), .h0_ready(h0_ready_z),
    .h1_address(h1_address), .h1_data_write(h1_data_write), .h1_write_mask(h1_write_mask),
    .h1_ren(h1_ren), .h1_wen(h1_wen), .h1_data_read(h1_data_read_z), .h1_ready(h1_ready_z),
    .dev_address(dev_address_z), .dev_data_write(dev_data_write_z),
    .dev_write_mask(dev_write_mask_z), .dev_ren(dev_ren_z), .dev_wen(dev_wen_z),
    .dev_data_read(dev_data_read), .dev_ready(dev_ready),
    .grant(grant_z), .bus_error(bus_error_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [1:0]  g_tab [8];
  logic [31:0] a_tab [8];

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    h0_address = '0; h0_data_write = '0; h0_write_mask = '0; h0_ren = 0; h0_wen = 0;
    h1_address = '0; h1_data_write = '0; h1_write_mask = '0; h1_ren = 0; h1_wen = 0;
    dev_data_read = '0; dev_ready = 0;
    tick();
    tick();

    // Reset state
    rst = 1'b0;
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_dev_ren", dev_ren, 1'b0);
    chk("rst_bus_error", bus_error, 1'b0);

    // 1. Single zero-wait read
    h0_ren = 1; h0_address = 32'h1000;
    #1;
    chk("t1_idle_grant", grant, 2'b00);
    chk("t1_idle_dev_ren", dev_ren, 1'b0);
    tick();
    dev_data_read = 32'hCAFEBABE; dev_ready = 1;
    #1;
    chk("t1_grant", grant, 2'b01);
    chk("t1_dev_address", dev_address, 32'h1000);
    chk("t1_dev_ren", dev_ren, 1'b1);
    chk("t1_h0_ready", h0_ready, 1'b1);
    chk("t1_h0_data_read", h0_data_read, 32'hCAFEBABE);
    chk("t1_h1_ready", h1_ready, 1'b0);
    tick();
    h0_ren = 0; dev_ready = 0;
    #1;
    chk("t1_back_idle", grant, 2'b00);
    chk("t1_h0_ready_low", h0_ready, 1'b0);
    chk("t1_h0_data_zero", h0_data_read, 32'h0);

    // 2. Contention fairness after reset
    rst = 1;
    tick();
    rst = 0;
    h0_ren = 1; h1_ren = 1; h0_address = 32'hA0; h1_address = 32'hB0;
    dev_ready = 1; dev_data_read = 32'h11112222;
    g_tab = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    a_tab = '{32'h0, 32'hA0, 32'h0, 32'hB0, 32'h0, 32'hA0, 32'h0, 32'hB0};
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) begin
        tick();
      end
      chk($sformatf("t2_grant_%0d", i), grant, g_tab[i]);
      chk($sformatf("t2_addr_%0d", i), dev_address, a_tab[i]);
      chk($sformatf("t2_h0_ready_%0d", i), h0_ready, g_tab[i] == 2'b01);
      chk($sformatf("t2_h1_ready_%0d", i), h1_ready, g_tab[i] == 2'b10);
      chk($sformatf("t2_h0_data_%0d", i), h0_data_read,
          (g_tab[i] == 2'b01) ? 32'h11112222 : 32'h0);
    end
    tick();
    h0_ren = 0; h1_ren = 0; dev_ready = 0;
    #1;
    chk("t2_idle", grant, 2'b00);
    tick();

    // 3. Write with three wait states; h0 arrives mid-transfer
    h1_wen = 1; h1_address = 32'h2000; h1_data_write = 32'h55AA00FF; h1_write_mask = 4'b0101;
    #1;
    chk("t3_idle_grant", grant, 2'b00);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) begin
        h0_ren = 1; h0_address = 32'h4000;
      end
      dev_ready = (i == 3);
      #1;
      chk($sformatf("t3_grant_%0d", i), grant, 2'b10);
      chk($sformatf("t3_wen_%0d", i), dev_wen, 1'b1);
      chk($sformatf("t3_ren_%0d", i), dev_ren, 1'b0);
      chk($sformatf("t3_wdata_%0d", i), dev_data_write, 32'h55AA00FF);
      chk($sformatf("t3_mask_%0d", i), dev_write_mask, 4'b0101);
      chk($sformatf("t3_addr_%0d", i), dev_address, 32'h2000);
      chk($sformatf("t3_h1_ready_%0d", i), h1_ready, i == 3);
      chk($sformatf("t3_h0_ready_%0d", i), h0_ready, 1'b0);
      chk($sformatf("t3_bus_error_%0d", i), bus_error, 1'b0);
    end
    tick();
    h1_wen = 0;
    #1;
    chk("t3_gap_idle", grant, 2'b00);
    chk("t3_gap_h1_ready", h1_ready, 1'b0);
    tick();
    #1;
    chk("t3_h0_grant", grant, 2'b01);
    chk("t3_h0_addr", dev_address, 32'h4000);
    chk("t3_h0_ready", h0_ready, 1'b1);
    tick();
    h0_ren = 0; dev_ready = 0;
    #1;
    chk("t3_end_idle", grant, 2'b00);

    // 4. Timeout at G+4, then dev_ready at G+4 wins over the watchdog
    tick();
    h0_ren = 1; h0_address = 32'h3000; dev_data_read = 32'h12345678;
    #1;
    chk("t4_idle", grant, 2'b00);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t4_grant_%0d", i), grant, 2'b01);
      chk($sformatf("t4_h0_ready_%0d", i), h0_ready, i == 4);
      chk($sformatf("t4_bus_error_%0d", i), bus_error, i == 4);
      chk($sformatf("t4_data_%0d", i), h0_data_read, (i == 4) ? 32'h0 : 32'h12345678);
      chk($sformatf("t4_dev_ren_%0d", i), dev_ren, i != 4);
    end
    tick();
    chk("t4_after_idle", grant, 2'b00);
    chk("t4_after_bus_error", bus_error, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      dev_ready = (i == 4);
      #1;
      chk($sformatf("t4b_grant_%0d", i), grant, 2'b01);
      chk($sformatf("t4b_h0_ready_%0d", i), h0_ready, i == 4);
      chk($sformatf("t4b_bus_error_%0d", i), bus_error, 1'b0);
      chk($sformatf("t4b_dev_ren_%0d", i), dev_ren, 1'b1);
      chk($sformatf("t4b_data_%0d", i), h0_data_read, 32'h12345678);
    end
    tick();
    h0_ren = 0; dev_ready = 0;
    #1;
    chk("t4b_idle", grant, 2'b00);

    // 5. Abort in the second owned cycle
    tick();
    h0_ren = 1;
    #1;
    tick();
    chk("t5_grant", grant, 2'b01);
    chk("t5_dev_ren", dev_ren, 1'b1);
    tick();
    h0_ren = 0;
    #1;
    chk("t5_abort_grant", grant, 2'b01);
    chk("t5_abort_ready", h0_ready, 1'b0);
    chk("t5_abort_dev_ren", dev_ren, 1'b0);
    chk("t5_abort_bus_error", bus_error, 1'b0);
    tick();
    chk("t5_abort_idle", grant, 2'b00);

    // 5b. Reset during OWN1, then a tie goes to host 0
    h1_ren = 1;
    #1;
    tick();
    chk("t5r_grant", grant, 2'b10);
    chk("t5r_dev_ren", dev_ren, 1'b1);
    rst = 1;
    tick();
    rst = 0; h0_ren = 1;
    #1;
    chk("t5r_grant_after_rst", grant, 2'b00);
    chk("t5r_dev_ren_after_rst", dev_ren, 1'b0);
    chk("t5r_dev_wen_after_rst", dev_wen, 1'b0);
    chk("t5r_h1_ready_after_rst", h1_ready, 1'b0);
    tick();
    dev_ready = 1;
    #1;
    chk("t5r_tie_grant", grant, 2'b01);
    chk("t5r_tie_ready", h0_ready, 1'b1);
    tick();
    h0_ren = 0; h1_ren = 0; dev_ready = 0;
    #1;
    chk("t5r_idle", grant, 2'b00);

    // 6. Watchdog disabled: the grant is held indefinitely
    rst = 1;
    tick();
    rst = 0; h0_ren = 1; dev_ready = 0;
    #1;
    chk("t6_idle", grant_z, 2'b00);
    for (int i = 0; i < 1000; i++) begin
      tick();
      chk($sformatf("t6_hold_%0d", i), {grant_z, h0_ready_z, h1_ready_z, bus_error_z},
          5'b01000);
    end
    h0_ren = 0;
    #1;
    chk("t6_abort_dev_ren", dev_ren_z, 1'b0);
    tick();
    chk("t6_end_idle", grant_z, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
